// File: rtl/fifo_if.sv
// -----------------------------------------------------------------------------
// fifo_if
// Purpose : groups the push/pop handshake and data signals of the fifo block.
// Signals :
//   write_en   - producer requests a push this cycle
//   write_data - element to push
//   read_en    - consumer requests a pop this cycle
//   read_data  - most recently popped element (registered in the fifo)
//   full       - fifo holds DEPTH elements
//   empty      - fifo holds no elements
// Modports:
//   master - the user side driving requests and observing status/data
//   slave  - the fifo side
// -----------------------------------------------------------------------------
interface fifo_if #(
   parameter type T = logic [31:0]
);
   logic write_en;
   T     write_data;
   logic read_en;
   T     read_data;
   logic full;
   logic empty;

   modport master (
      output write_en,
      output write_data,
      output read_en,
      input  read_data,
      input  full,
      input  empty
   );

   modport slave (
      input  write_en,
      input  write_data,
      input  read_en,
      output read_data,
      output full,
      output empty
   );
endinterface

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Purpose : single-clock circular-buffer FIFO with a registered read port.
//           A pop loads the head element into read_data on the same edge; the
//           value then holds until the next accepted pop. full/empty are
//           registered copies of the post-edge occupancy state.
// Ports   :
//   clk    - single clock, all state changes on its rising edge
//   reset  - synchronous active-high reset; clears pointers, count, read_data
//   bus    - fifo_if.slave: write_en/write_data/read_en in,
//            read_data/full/empty out
// Parameters:
//   T      - element type
//   DEPTH  - number of storage entries (>= 2, need not be a power of two)
// -----------------------------------------------------------------------------
module fifo #(
   parameter type T     = logic [31:0],
   parameter int  DEPTH = 8
) (
   input  logic  clk,
   input  logic  reset,
   fifo_if.slave bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // Pointer advance with explicit wrap, since DEPTH may not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == PTR_LAST) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + PW'(1);
      end
      return nxt;
   endfunction

   T              r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   T              r_read_data;
   logic          r_full;
   logic          r_empty;

   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_count_next;
   logic [PW-1:0] w_wr_ptr_next;
   logic [PW-1:0] w_rd_ptr_next;

   // Accept decisions use the pre-edge registered flags.
   assign w_push = bus.write_en && !r_full;
   assign w_pop  = bus.read_en  && !r_empty;

   // Next-state computation for count and pointers.
   always_comb begin
      w_count_next  = r_count;
      w_wr_ptr_next = r_wr_ptr;
      w_rd_ptr_next = r_rd_ptr;

      if (w_push) begin
         w_wr_ptr_next = ptr_inc(r_wr_ptr);
      end else begin
         w_wr_ptr_next = r_wr_ptr;
      end

      if (w_pop) begin
         w_rd_ptr_next = ptr_inc(r_rd_ptr);
      end else begin
         w_rd_ptr_next = r_rd_ptr;
      end

      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CNT_ONE;
         2'b01:   w_count_next = r_count - CNT_ONE;
         default: w_count_next = r_count;
      endcase
   end

   // Control state: pointers, count, status flags and the read data register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= {PW{1'b0}};
         r_rd_ptr    <= {PW{1'b0}};
         r_count     <= {CW{1'b0}};
         r_read_data <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
         r_count  <= w_count_next;
         r_full   <= (w_count_next == CNT_FULL);
         r_empty  <= (w_count_next == {CW{1'b0}});
         if (w_pop) begin
            r_read_data <= r_mem[r_rd_ptr];
         end
      end
   end

   // Storage array; contents are not cleared by reset, only pointers are.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= bus.write_data;
      end
   end

   assign bus.read_data = r_read_data;
   assign bus.full      = r_full;
   assign bus.empty     = r_empty;

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo
// Purpose : self-checking bench for fifo (DEPTH=8, 32-bit elements). A queue
//           holds the elements the bench believes are stored; each accepted
//           pop takes the expected read_data from its head, and full/empty
//           are derived from the queue size.
// -----------------------------------------------------------------------------
module tb_fifo;

   localparam int DEPTH = 8;
   typedef logic [31:0] data_t;

   logic clk;
   logic reset;

   fifo_if #(.T(data_t)) bus ();

   fifo #(.T(data_t), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    checks;
   int    failures;
   data_t sb_q[$];
   data_t exp_rd;

   // Single comparison point: counts and reports any mismatch.
   task automatic chk(input string tag, input data_t obs, input data_t exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, update the scoreboard with pre-edge
   // acceptance, then compare outputs 1 time unit after the edge.
   task automatic step(input logic we, input data_t wd, input logic re,
                       input logic rst, input string tag);
      bit push_ok;
      bit pop_ok;
      reset        = rst;
      bus.write_en = we;
      bus.write_data = wd;
      bus.read_en  = re;
      push_ok = we && (sb_q.size() < DEPTH);
      pop_ok  = re && (sb_q.size() > 0);
      @(posedge clk);
      #1;
      if (rst) begin
         sb_q.delete();
         exp_rd = 32'h0;
      end else begin
         if (pop_ok) exp_rd = sb_q.pop_front();
         if (push_ok) sb_q.push_back(wd);
      end
      chk({tag, ".rd"},    bus.read_data, exp_rd);
      chk({tag, ".full"},  {31'h0, bus.full},  {31'h0, (sb_q.size() == DEPTH)});
      chk({tag, ".empty"}, {31'h0, bus.empty}, {31'h0, (sb_q.size() == 0)});
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_rd   = 32'h0;
      reset    = 1'b1;
      bus.write_en   = 1'b0;
      bus.write_data = 32'h0;
      bus.read_en    = 1'b0;

      // Reset held for 3 cycles, then release.
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, "rst");
      step(1'b0, 32'h0, 1'b0, 1'b0, "rst_rel");
      chk("rst.empty_abs", {31'h0, bus.empty}, 32'h1);
      chk("rst.full_abs",  {31'h0, bus.full},  32'h0);
      chk("rst.rd_abs",    bus.read_data,      32'h0);

      // Fill with 0..7, then 8..10 must be dropped.
      for (int i = 0; i < 11; i++) step(1'b1, data_t'(i), 1'b0, 1'b0, "fill");
      chk("fill.full_abs", {31'h0, bus.full}, 32'h1);

      // Drain with read_en held; extra edges hold read_data at 7.
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
      chk("drain.rd_abs",    bus.read_data,      32'h7);
      chk("drain.empty_abs", {31'h0, bus.empty}, 32'h1);

      // Pop while empty with a push: push only.
      step(1'b1, 32'h55, 1'b1, 1'b0, "empty_rw");
      step(1'b0, 32'h0,  1'b1, 1'b0, "empty_rw_pop");
      chk("empty_rw.rd_abs", bus.read_data, 32'h55);

      // Count=4 then simultaneous push/pop for 3 cycles.
      for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + data_t'(i), 1'b0, 1'b0, "pre4");
      for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + data_t'(i), 1'b1, 1'b0, "both");
      chk("both.rd_abs", bus.read_data, 32'h102);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "both_drain");
      chk("both_drain.rd_abs", bus.read_data, 32'h202);

      // Full with read_en: pop proceeds, push dropped.
      for (int i = 0; i < 8; i++) step(1'b1, 32'h300 + data_t'(i), 1'b0, 1'b0, "refill");
      step(1'b1, 32'hDEAD, 1'b1, 1'b0, "full_rw");
      chk("full_rw.full_abs", {31'h0, bus.full}, 32'h0);
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "full_rw_drain");
      chk("full_rw_drain.rd_abs", bus.read_data, 32'h307);

      // Pointer wrap: push 6, pop 6, push 5, pop 5.
      for (int i = 0; i < 6; i++) step(1'b1, 32'h400 + data_t'(i), 1'b0, 1'b0, "wrap_p6");
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "wrap_r6");
      for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + data_t'(i), 1'b0, 1'b0, "wrap_p5");
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "wrap_r5");
      chk("wrap.rd_abs", bus.read_data, 32'h504);

      // Mid-operation reset discards stored data.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + data_t'(i), 1'b0, 1'b0, "mid_p3");
      step(1'b1, 32'hBEEF, 1'b1, 1'b1, "mid_rst");
      step(1'b1, 32'hA5, 1'b0, 1'b0, "mid_pA5");
      step(1'b0, 32'h0,  1'b1, 1'b0, "mid_pop");
      chk("mid.rd_abs",    bus.read_data,      32'hA5);
      chk("mid.empty_abs", {31'h0, bus.empty}, 32'h1);

      // Random traffic across many wraps.
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), data_t'($urandom), 1'($urandom_range(0, 1)),
              1'b0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter T SHALL be a type, default logic [31:0], giving the data element type.
REQ-002 Parameter DEPTH SHALL be an int, default 8, giving the storage entry count; legal range is DEPTH >= 2, any integer.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-high reset.
REQ-005 write_en  input  1  SHALL request a push of write_data this cycle.
REQ-006 write_data  input  T  SHALL be the element to push.
REQ-007 read_en  input  1  SHALL request a pop this cycle.
REQ-008 read_data  output  T  SHALL be a registered output holding the most recently popped element.
REQ-009 full  output  1  SHALL be 1 when the occupancy count equals DEPTH.
REQ-010 empty  output  1  SHALL be 1 when the occupancy count equals 0.

Function
REQ-011 Storage SHALL be a circular buffer of DEPTH entries with a write pointer, a read pointer and an occupancy count of width clog2(DEPTH+1).
REQ-012 Push accepted SHALL be defined as (write_en && !full), using pre-edge full.
REQ-013 Pop accepted SHALL be defined as (read_en && !empty), using pre-edge empty.
REQ-014 On an accepted push, write_data SHALL be stored at the write pointer, and the write pointer SHALL advance by 1, wrapping from DEPTH-1 to 0.
REQ-015 On an accepted pop, read_data SHALL load the entry at the read pointer on that edge (1-cycle latency), and the read pointer SHALL advance by 1 with the same wrap rule.
REQ-016 When no pop is accepted, read_data SHALL hold its previous value.
REQ-017 Count SHALL increment on push-only, decrement on pop-only, and be unchanged on both or neither.
REQ-018 Push while full with no accepted pop SHALL be dropped, with no change to storage, pointers or count.
REQ-019 Push while full with read_en=1 SHALL also be dropped; the pop still proceeds and count becomes DEPTH-1.
REQ-020 Pop while empty SHALL be ignored, and read_data SHALL hold; push while empty with read_en=1 SHALL perform the push only.
REQ-021 full and empty SHALL be registered or derived combinationally from the registered count, and SHALL reflect the post-edge count in the cycle after the edge.
REQ-022 Elements SHALL be returned in strict first-in-first-out order across any number of pointer wraps.

Reset
REQ-023 When reset=1 at a rising edge, the write pointer, read pointer and count SHALL clear to 0, read_data SHALL clear to '0, empty SHALL be 1 and full SHALL be 0.
REQ-024 Reset SHALL take priority over simultaneous write_en and read_en; storage contents need not be cleared.
REQ-025 Reset asserted mid-operation SHALL discard all stored elements, so that the next pop after release returns only data pushed after release.

Verification
REQ-026 Hold reset for 3 cycles, then release -> empty=1, full=0, read_data=0.
REQ-027 Push 0..7 on consecutive cycles (DEPTH=8), then attempt pushes of 8, 9 and 10 -> full=1 after the 8th push; values 8-10 are dropped and count stays 8.
REQ-028 Hold read_en=1 from the full state -> read_data shows 0,1,...,7 on successive edges; empty=1 after the 8th pop; further edges hold read_data=7.
REQ-029 With count=4, assert write_en and read_en together for 3 cycles -> count stays 4 and output order is preserved.
REQ-030 Push 6, pop 6, push 5, pop 5 (pointer wrap) -> data returned in push order with no loss or duplication.
REQ-031 Push 3 elements, assert reset for 1 cycle, push 0xA5, then pop -> read_data=0xA5, then empty=1.
